// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel-strobe divider plus h/v raster counters.
// Every output is decoded combinationally from the registered counters.
module vga_timing_gen #(
  parameter int PIX_DIV = 2
) (
  input  logic       clk_in,
  input  logic       i_rst,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_pix_stb,
  output logic       o_active,
  output logic       o_blanking,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_screenend,
  output logic       o_animate
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic [9:0] H_VIS_END  = 10'd640;
  localparam logic [9:0] H_SYNC_BEG = 10'd656;
  localparam logic [9:0] H_SYNC_END = 10'd751;
  localparam logic [9:0] H_LAST     = 10'd799;
  localparam logic [9:0] V_VIS_END  = 10'd480;
  localparam logic [9:0] V_SYNC_BEG = 10'd490;
  localparam logic [9:0] V_SYNC_END = 10'd491;
  localparam logic [9:0] V_ANIM     = 10'd479;
  localparam logic [9:0] V_LAST     = 10'd524;

  logic [DW-1:0] div_cnt;
  logic [9:0]    h_count;
  logic [9:0]    v_count;
  logic          pix_stb;

  // With PIX_DIV=1 DIV_LAST is 0, so the strobe is permanently high.
  assign pix_stb = (div_cnt == DIV_LAST);

  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
    end else if (pix_stb) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge i_rst) begin
    if (i_rst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_stb) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        if (v_count == V_LAST) begin
          v_count <= '0;
        end else begin
          v_count <= v_count + 1'b1;
        end
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  logic h_vis;
  logic v_vis;

  assign h_vis = (h_count < H_VIS_END);
  assign v_vis = (v_count < V_VIS_END);

  assign o_pix_stb   = pix_stb;
  assign o_hs        = !((h_count >= H_SYNC_BEG) && (h_count <= H_SYNC_END));
  assign o_vs        = !((v_count >= V_SYNC_BEG) && (v_count <= V_SYNC_END));
  assign o_active    = h_vis && v_vis;
  assign o_blanking  = !(h_vis && v_vis);
  // Coordinates clamp at the last visible pixel/line during blanking.
  assign o_x         = h_vis ? h_count : 10'd639;
  assign o_y         = v_vis ? v_count[8:0] : 9'd479;
  assign o_screenend = (h_count == H_LAST) && (v_count == V_LAST);
  assign o_animate   = (h_count == H_LAST) && (v_count == V_ANIM);

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL have parameter PIX_DIV, default 2, meaning clk_in cycles per pixel; legal range is 1..16.
REQ-002 clk_in  input  1  board clock; this is the only clock, and all state changes on its rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 o_hs  output  1  horizontal sync, active low.
REQ-005 o_vs  output  1  vertical sync, active low.
REQ-006 o_pix_stb  output  1  one-clk_in-cycle pixel strobe.
REQ-007 o_active  output  1  high while inside the 640x480 visible area.
REQ-008 o_blanking  output  1  complement of o_active.
REQ-009 o_x  output  10  current visible pixel column, 0..639.
REQ-010 o_y  output  9  current visible pixel row, 0..479.
REQ-011 o_screenend  output  1  high for exactly one pixel period, at the last pixel of the frame (h=799, v=524).
REQ-012 o_animate  output  1  high for exactly one pixel period at h=799, v=479 (end of the last visible line); this is the game-logic update tick.

Function
REQ-013 The strobe divider SHALL count 0..PIX_DIV-1 on every clk_in and assert o_pix_stb in the cycle where the count equals PIX_DIV-1. With PIX_DIV=1, o_pix_stb SHALL be constantly high.
REQ-014 h_count (10 bit) and v_count (10 bit) SHALL advance only in cycles where o_pix_stb=1.
REQ-015 h_count SHALL count 0..799 and wrap to 0. On that wrap, v_count SHALL increment.
REQ-016 v_count SHALL count 0..524 and wrap to 0 when it is at 524 and h_count wraps; both counters SHALL reach 0 in the same strobe.
REQ-017 Horizontal timing SHALL be: visible 0..639, front porch 640..655, sync 656..751, back porch 752..799.
REQ-018 Vertical timing SHALL be: visible 0..479, front porch 480..489, sync 490..491, back porch 492..524.
REQ-019 o_hs SHALL be 0 exactly when 656<=h_count<=751, and 1 otherwise.
REQ-020 o_vs SHALL be 0 exactly when 490<=v_count<=491, and 1 otherwise.
REQ-021 o_active SHALL be 1 exactly when h_count<640 and v_count<480.
REQ-022 o_x SHALL equal h_count when h_count<640, and SHALL hold at 639 otherwise.
REQ-023 o_y SHALL equal v_count[8:0] when v_count<480, and SHALL hold at 479 otherwise.
REQ-024 All outputs SHALL be decoded combinationally from registered counters only, with no further state. An output change SHALL be visible in the same clk_in cycle as the counter update.
REQ-025 o_screenend and o_animate SHALL be decoded from the counter values, not gated by o_pix_stb. Each is therefore high for PIX_DIV clk_in cycles, i.e. one pixel period.
REQ-026 Comparisons SHALL be unsigned. No counter SHALL ever exceed its terminal value (799 / 524 / PIX_DIV-1).

Reset
REQ-027 While i_rst=1, regardless of clk_in: h_count=0, v_count=0, divider=0.
REQ-028 While i_rst=1, outputs SHALL be: o_hs=1, o_vs=1, o_active=1, o_blanking=0, o_x=0, o_y=0, o_screenend=0, o_animate=0.
REQ-029 o_pix_stb SHALL be 0 during reset when PIX_DIV>1.
REQ-030 After i_rst deasserts, the first o_pix_stb SHALL occur PIX_DIV clk_in cycles later, and h_count SHALL become 1 on that strobe.
REQ-031 Reset asserted mid-line or mid-frame SHALL clear the module immediately (asynchronously). Output returns to the REQ-027/028 values with no partial-line completion.

Verification
REQ-032 Scenario 1: PIX_DIV=2, reset released, run one frame.
- o_pix_stb period is 2 clocks.
- Exactly 800*525=420000 strobes occur before h=0, v=0 recurs.
REQ-033 Scenario 2: check horizontal sync position and width.
- o_hs falls at h_count 656 and rises at 752.
- Low width is 96 pixels = 192 clk_in.
- o_active falls at h=640.
REQ-034 Scenario 3: check vertical sync position and width.
- o_vs is low for lines 490 and 491 only (1600 pixels).
- o_active is 0 for all of v=480..524.
REQ-035 Scenario 4: check clamping and the animate tick.
- At h=700, v=100: o_x=639, o_y=100.
- At h=5, v=500: o_x=5, o_y=479.
- o_animate high only at h=799, v=479 (once per frame).
- o_screenend high only at h=799, v=524 (once per frame).
REQ-036 Scenario 5: assert i_rst asynchronously at h=300, v=200, between clock edges.
- All outputs take the reset values before the next clk_in edge.
- After release, h_count=1 on the first strobe.
REQ-037 Scenario 6: PIX_DIV=1.
- o_pix_stb is constantly 1.
- A full frame takes 420000 clk_in cycles.
